// File: rtl/adpcm_enc_packer.sv
// adpcm_enc_packer: encode-mode sequencer for the adpcm core, packs 4-bit codes two per byte into a show-ahead FIFO
//   clk, rstn       clock, asynchronous active-low reset
//   enable          block enable (also the core enable)
//   pcm_valid/ready/data   16-bit signed PCM sample stream in
//   flush           pulse: emit a pending half byte as {4'h0, nibble}
//   core_req/ack/pcm/adpcm toggle-req / rising-ack interface to the core
//   byte_valid/ready/data  packed byte stream out (show-ahead)
//   fifo_level      bytes stored, half_pending low nibble held
//   timeout_err     sticky ack-timeout flag
module adpcm_enc_packer #(
   parameter int SETUP_CYC   = 5,
   parameter int ACK_TIMEOUT = 64,
   parameter int DEPTH       = 4
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      enable,
   input  logic                      pcm_valid,
   output logic                      pcm_ready,
   input  logic signed [15:0]        pcm_data,
   input  logic                      flush,
   output logic                      core_req,
   input  logic                      core_ack,
   output logic signed [15:0]        core_pcm,
   input  logic [3:0]                core_adpcm,
   output logic                      byte_valid,
   input  logic                      byte_ready,
   output logic [7:0]                byte_data,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic                      half_pending,
   output logic                      timeout_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(SETUP_CYC + ACK_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, PACK} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic ack_q, ack_rise, full, flush_ok, push, pop;
   logic [3:0] code_q, nib;
   logic [7:0] push_data;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   // accept is gated on FIFO space, so a PACK push can never overflow
   always_comb begin
      ack_rise   = core_ack & ~ack_q;
      full       = fifo_level == (AW+1)'(DEPTH);
      flush_ok   = flush & half_pending & ~full & (state == IDLE);
      pcm_ready  = rstn & enable & ~full & ~flush_ok & (state == IDLE);
      push       = flush_ok | ((state == PACK) & half_pending);
      push_data  = flush_ok ? {4'h0, nib} : {code_q, nib};
      byte_valid = fifo_level != '0;
      pop        = byte_valid & byte_ready;
      byte_data  = byte_valid ? mem[rd_ptr] : 8'h0;
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= push_data;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         cnt          <= '0;
         core_req     <= 1'b0;
         core_pcm     <= '0;
         ack_q        <= 1'b0;
         code_q       <= '0;
         nib          <= '0;
         half_pending <= 1'b0;
         timeout_err  <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
      end else begin
         ack_q      <= core_ack;
         wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
         fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
         if (flush_ok) half_pending <= 1'b0;
         case (state)
            IDLE:
               if (pcm_valid & pcm_ready) begin
                  core_pcm <= pcm_data;
                  cnt      <= '0;
                  state    <= SETUP;
               end
            SETUP:
               if (cnt == CW'(SETUP_CYC - 1)) begin
                  core_req <= ~core_req;
                  cnt      <= '0;
                  state    <= WAIT_ACK;
               end else cnt <= cnt + CW'(1);
            WAIT_ACK:
               if (ack_rise) begin
                  code_q <= core_adpcm;
                  state  <= PACK;
               end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else cnt <= cnt + CW'(1);
            PACK: begin
               if (!half_pending) nib <= code_q;
               half_pending <= ~half_pending;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/adpcm_enc_packer.md
Name: adpcm_enc_packer

Overview:
Upstream sequencer and downstream packer for the adpcm core in encode mode (sel_rx=0). Accepts 16-bit signed PCM samples on a valid/ready stream. Presents each sample to the core with the core's toggle-req / rising-ack handshake and captures the returned 4-bit code. Packs codes two per byte and buffers the bytes in a small show-ahead FIFO for a byte-stream consumer.

Parameters:
SETUP_CYC, 5, cycles core_pcm is held stable before core_req toggles (min 1)
ACK_TIMEOUT, 64, cycles waited for core_ack rise before abandoning a request (min 2)
DEPTH, 4, output FIFO depth in bytes (power of 2, ≥2)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
enable  in  1  block enable; also drives core enable
pcm_valid  in  1  input sample valid
pcm_ready  out  1  input sample accepted when valid&ready
pcm_data  in  16  signed PCM sample
flush  in  1  single-cycle pulse: emit pending half byte
core_req  out  1  toggle request to adpcm core
core_ack  in  1  core acknowledge; rising edge completes request
core_pcm  out  16  sample driven to core rx_pcm
core_adpcm  in  4  code from core tx_adpcm
byte_valid  out  1  FIFO non-empty
byte_ready  in  1  consumer pop when valid&ready
byte_data  out  8  FIFO head byte
fifo_level  out  $clog2(DEPTH)+1  bytes stored
half_pending  out  1  low nibble held, high nibble not yet received
timeout_err  out  1  sticky; set on ack timeout, cleared only by reset

Behaviour:
- Reset (async, rstn=0): FSM=IDLE, core_req=0, core_pcm=0, pcm_ready=0, FIFO empty (byte_valid=0, fifo_level=0, byte_data=0), half_pending=0, nibble reg=0, timeout_err=0, ack edge register=0. Reset mid-request abandons it without waiting for ack.
- Ack edge detect: ack_q registered from core_ack. ack_rise = core_ack & ~ack_q. Only ack_rise in WAIT_ACK completes a request; ack_rise in other states is ignored.
- FSM:
  - IDLE: pcm_ready = enable & (fifo_level<DEPTH). On accept: core_pcm<=pcm_data, counter<=0, go to SETUP.
  - SETUP: counter counts up. When counter reaches SETUP_CYC-1: core_req<=~core_req, counter<=0, go to WAIT_ACK.
  - WAIT_ACK, on ack_rise: capture core_adpcm, go to PACK.
  - WAIT_ACK, timeout: if counter reaches ACK_TIMEOUT-1 with no ack_rise, set timeout_err, discard the sample (no nibble), go to IDLE.
  - PACK, one cycle:
    - half_pending=0: code goes to nibble reg, half_pending<=1.
    - half_pending=1: push {code, nibble_reg} (first code in bits[3:0], second in [7:4]), half_pending<=0.
    - Return to IDLE.
- Latency: accept to core_req toggle = SETUP_CYC cycles. ack_rise to FIFO push (second nibble) = 2 cycles (PACK, then visible on byte_valid next cycle).
- Space guarantee: accept is gated on FIFO not full, so a PACK push always finds room. No overflow path exists.
- Flush:
  - Honoured only in IDLE with half_pending=1 and FIFO not full. Pushes {4'h0, nibble_reg} and clears half_pending.
  - Flush in any other state or condition is ignored; it is not queued.
  - If flush and pcm_valid arrive in the same IDLE cycle, flush wins and pcm_ready=0 that cycle.
- enable deassert:
  - pcm_ready falls immediately.
  - An in-flight request (SETUP/WAIT_ACK/PACK) runs to completion or timeout.
  - half_pending and FIFO contents are retained; the FIFO keeps draining.
- FIFO:
  - show-ahead; byte_data = head while byte_valid, else 0.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: both take effect, fifo_level unchanged. Pop on empty is ignored.
- core_req toggles exactly once per accepted sample. core_pcm is stable from accept until the next accept.

Test Plan:
- Reset mid-WAIT_ACK: assert rstn=0 while the core is busy -> core_req=0, fifo_level=0, half_pending=0, pcm_ready=0 immediately. After release, the next sample toggles core_req from 0.
- Two samples 16'sd1000 and -16'sd1000 with a core model returning 4'h3 then 4'hB, byte_ready=1 -> one byte 8'hB3. half_pending is 1 after the first code and 0 after the second. core_req toggles SETUP_CYC=5 cycles after each accept.
- Flush: three samples with codes 4'h1,4'h2,4'h7, then flush in IDLE -> bytes 8'h21 then 8'h07, half_pending=0. A second flush produces nothing.
- Backpressure: byte_ready=0 with 10 codes supplied -> fifo_level reaches 4 (DEPTH=4) and pcm_ready stays 0. Releasing byte_ready drains bytes in order, and acceptance resumes once fifo_level<4.
- Ack timeout: core model never raises ack -> after 5+64 cycles timeout_err=1, FSM returns to IDLE, no nibble is recorded. The next sample with a normal ack packs correctly and timeout_err stays 1.
- Simultaneous push/pop at fifo_level=2: PACK push and byte pop in the same cycle -> fifo_level stays 2, byte order preserved across pointer wrap (8+ bytes total).
